imem_port_arbiter: RTL and testbench

//  Shares the single-ported instruction memory between two requesters: the IF-stage fetch

---
 rtl/imem_port_arbiter.sv | 105 ++++++++++
 tb/tb_imem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one single-ported instruction memory between the IF fetch port
// and the loader/debug port; loader has priority, fetch is guaranteed a slot after a bounded run.
module imem_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_W    = 5,
  parameter int MAX_LD_RUN = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               if_req_i,
  input  logic [31:0]        if_addr_i,
  output logic               if_gnt_o,
  output logic               if_stall_o,
  output logic               if_rvalid_o,
  output logic [DATA_W-1:0]  if_rdata_o,
  input  logic               ld_req_i,
  input  logic               ld_we_i,
  input  logic [31:0]        ld_addr_i,
  input  logic [DATA_W-1:0]  ld_wdata_i,
  output logic               ld_gnt_o,
  output logic               ld_rvalid_o,
  output logic [DATA_W-1:0]  ld_rdata_o,
  output logic               addr_err_o,
  output logic               mem_en_o,
  output logic               mem_we_o,
  output logic [DEPTH_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0]  mem_wdata_o,
  input  logic [DATA_W-1:0]  mem_rdata_i
);

  localparam int CNT_W = $clog2(MAX_LD_RUN + 1);
  localparam logic [CNT_W-1:0] RUN_LIMIT = CNT_W'(MAX_LD_RUN);

  logic [CNT_W-1:0]   r_runCnt;
  logic               r_ifRvalid;
  logic               r_ldRvalid;
  logic               r_addrErr;
  logic               w_ifGnt;
  logic               w_ldGnt;
  logic [DEPTH_W-1:0] w_memAddr;
  logic               w_misaligned;
  logic               w_unused;

  // Grants are held low during reset so every output reads 0 while rst_i is high.
  always_comb begin
    w_ldGnt = 1'b0;
    w_ifGnt = 1'b0;
    if (!rst_i) begin
      w_ldGnt = ld_req_i & (~if_req_i | (r_runCnt != RUN_LIMIT));
      w_ifGnt = if_req_i & ~w_ldGnt;
    end
  end

  always_comb begin
    w_memAddr    = '0;
    w_misaligned = 1'b0;
    if (w_ldGnt) begin
      w_memAddr    = ld_addr_i[DEPTH_W+1:2];
      w_misaligned = |ld_addr_i[1:0];
    end else if (w_ifGnt) begin
      w_memAddr    = if_addr_i[DEPTH_W+1:2];
      w_misaligned = |if_addr_i[1:0];
    end
  end

  // Upper address bits fall outside the memory and simply wrap.
  assign w_unused = ^{if_addr_i[31:DEPTH_W+2], ld_addr_i[31:DEPTH_W+2]};

  // Run counter only grows while fetch is actually waiting behind the loader.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_runCnt <= '0;
    end else if (!if_req_i || w_ifGnt) begin
      r_runCnt <= '0;
    end else if (w_ldGnt && (r_runCnt != RUN_LIMIT)) begin
      r_runCnt <= r_runCnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ifRvalid <= 1'b0;
      r_ldRvalid <= 1'b0;
      r_addrErr  <= 1'b0;
    end else begin
      r_ifRvalid <= w_ifGnt;
      r_ldRvalid <= w_ldGnt & ~ld_we_i;
      r_addrErr  <= w_misaligned;
    end
  end

  assign if_gnt_o    = w_ifGnt;
  assign ld_gnt_o    = w_ldGnt;
  assign if_stall_o  = if_req_i & ~w_ifGnt & ~rst_i;
  assign mem_en_o    = w_ifGnt | w_ldGnt;
  assign mem_we_o    = w_ldGnt & ld_we_i;
  assign mem_addr_o  = w_memAddr;
  assign mem_wdata_o = w_ldGnt ? ld_wdata_i : '0;
  assign if_rvalid_o = r_ifRvalid;
  assign ld_rvalid_o = r_ldRvalid;
  assign if_rdata_o  = r_ifRvalid ? mem_rdata_i : '0;
  assign ld_rdata_o  = r_ldRvalid ? mem_rdata_i : '0;
  assign addr_err_o  = r_addrErr;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: directed and randomized checks of imem_port_arbiter against a
// transaction-level model of arbitration, read return and a reference copy of memory.
`timescale 1ns/1ps
module tb_imem_port_arbiter;

  localparam int DATA_W     = 32;
  localparam int DEPTH_W    = 5;
  localparam int MAX_LD_RUN = 4;
  localparam int DEPTH      = 1 << DEPTH_W;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               ifReq = 1'b0;
  logic [31:0]        ifAddr = '0;
  logic               ldReq = 1'b0;
  logic               ldWe = 1'b0;
  logic [31:0]        ldAddr = '0;
  logic [DATA_W-1:0]  ldWdata = '0;
  logic               ifGnt, ifStall, ifRvalid, ldGnt, ldRvalid, addrErr;
  logic               memEn, memWe;
  logic [DATA_W-1:0]  ifRdata, ldRdata, memWdata;
  logic [DEPTH_W-1:0] memAddr;
  logic [DATA_W-1:0]  memRdata = '0;

  logic [DATA_W-1:0]  envMem [DEPTH];
  logic [DATA_W-1:0]  refMem [DEPTH];

  int                 mRun = 0;
  bit                 mIfRv = 1'b0, mLdRv = 1'b0, mErr = 1'b0;
  bit                 mGl, mGi, eL, eI;
  logic [DATA_W-1:0]  mIfData = '0, mLdData = '0;

  int                 nVectors = 0;
  int                 nMiscompares = 0;

  imem_port_arbiter #(.DATA_W(DATA_W), .DEPTH_W(DEPTH_W), .MAX_LD_RUN(MAX_LD_RUN)) dut (
    .clk_i(clk), .rst_i(rst),
    .if_req_i(ifReq), .if_addr_i(ifAddr), .if_gnt_o(ifGnt), .if_stall_o(ifStall),
    .if_rvalid_o(ifRvalid), .if_rdata_o(ifRdata),
    .ld_req_i(ldReq), .ld_we_i(ldWe), .ld_addr_i(ldAddr), .ld_wdata_i(ldWdata),
    .ld_gnt_o(ldGnt), .ld_rvalid_o(ldRvalid), .ld_rdata_o(ldRdata),
    .addr_err_o(addrErr), .mem_en_o(memEn), .mem_we_o(memWe), .mem_addr_o(memAddr),
    .mem_wdata_o(memWdata), .mem_rdata_i(memRdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-ported synchronous memory attached to the DUT.
  always @(posedge clk) begin
    if (memEn) begin
      if (memWe) envMem[memAddr] <= memWdata;
      else       memRdata <= envMem[memAddr];
    end
  end

  function automatic bit expLdGnt();
    if (rst || !ldReq) return 1'b0;
    if (!ifReq) return 1'b1;
    return mRun < MAX_LD_RUN;
  endfunction

  function automatic bit expIfGnt();
    return !rst && ifReq && !expLdGnt();
  endfunction

  function automatic int wordIdx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit iReq, input logic [31:0] iAddr, input bit lReq,
                               input bit lWe, input logic [31:0] lAddr, input logic [31:0] lWdata);
    @(posedge clk);
    #1;
    ifReq   = iReq;
    ifAddr  = iAddr;
    ldReq   = lReq;
    ldWe    = lWe;
    ldAddr  = lAddr;
    ldWdata = lWdata;
  endtask

  function automatic logic [31:0] randAddr();
    logic [31:0] a;
    a = ($urandom_range(0, 7) == 0) ? 32'($urandom()) : 32'($urandom_range(0, 127));
    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  // Model state advances once per accepted cycle; reset clears everything at once.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mRun    = 0;
      mIfRv   = 1'b0;
      mLdRv   = 1'b0;
      mErr    = 1'b0;
      mIfData = '0;
      mLdData = '0;
    end else begin
      mGl     = expLdGnt();
      mGi     = expIfGnt();
      mIfRv   = mGi;
      mLdRv   = mGl && !ldWe;
      mIfData = mGi ? refMem[wordIdx(ifAddr)] : '0;
      mLdData = (mGl && !ldWe) ? refMem[wordIdx(ldAddr)] : '0;
      mErr    = (mGi && ifAddr[1:0] != 2'b00) || (mGl && ldAddr[1:0] != 2'b00);
      if (mGl && ldWe) refMem[wordIdx(ldAddr)] = ldWdata;
      if (!ifReq || mGi) mRun = 0;
      else if (mGl && mRun < MAX_LD_RUN) mRun = mRun + 1;
    end
  end

  always @(negedge clk) begin
    eL = expLdGnt();
    eI = expIfGnt();
    checkOutput("if_gnt", ifGnt, eI);
    checkOutput("ld_gnt", ldGnt, eL);
    checkOutput("if_stall", ifStall, !rst && ifReq && !eI);
    checkOutput("mem_en", memEn, eI || eL);
    checkOutput("mem_we", memWe, eL && ldWe);
    checkOutput("mem_wdata", memWdata, eL ? ldWdata : '0);
    if (eL)      checkOutput("mem_addr_ld", memAddr, wordIdx(ldAddr));
    else if (eI) checkOutput("mem_addr_if", memAddr, wordIdx(ifAddr));
    checkOutput("if_rvalid", ifRvalid, mIfRv);
    checkOutput("if_rdata", ifRdata, mIfData);
    checkOutput("ld_rvalid", ldRvalid, mLdRv);
    checkOutput("ld_rdata", ldRdata, mLdData);
    checkOutput("addr_err", addrErr, mErr);
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      envMem[i] = 32'hC0DE0000 | i;
      refMem[i] = 32'hC0DE0000 | i;
    end

    #3;
    checkOutput("reset_if_gnt", ifGnt, 0);
    checkOutput("reset_mem_en", memEn, 0);
    checkOutput("reset_if_rvalid", ifRvalid, 0);
    checkOutput("reset_addr_err", addrErr, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset asserted in the middle of a granted fetch read.
    applyStimulus(1, 32'h10, 0, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_if_gnt", ifGnt, 0);
    checkOutput("midrst_mem_en", memEn, 0);
    checkOutput("midrst_if_stall", ifStall, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_no_rvalid", ifRvalid, 0);

    // Fetch-only stream, one word per cycle.
    for (int i = 0; i < 5; i++) begin
      if (i < 4) applyStimulus(1, 32'(4 * i), 0, 0, 0, 0);
      else       applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      if (i < 4) checkOutput("stream_stall", ifStall, 0);
      if (i > 0) begin
        checkOutput("stream_rvalid", ifRvalid, 1);
        checkOutput("stream_rdata", ifRdata, 32'hC0DE0000 + 32'(i - 1));
      end
    end

    // Loader write then fetch of the same word.
    applyStimulus(0, 0, 1, 1, 32'h0, 32'h0032A383);
    applyStimulus(1, 32'h0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("raw_rvalid", ifRvalid, 1);
    checkOutput("raw_rdata", ifRdata, 32'h0032A383);

    // Continuous contention: four loader grants, then one fetch grant.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 32'h40, 1, 0, 32'h20, 0);
      @(negedge clk);
      checkOutput("contend_ld_gnt", ldGnt, (i % 5) != 4);
      checkOutput("contend_if_gnt", ifGnt, (i % 5) == 4);
      checkOutput("contend_stall", ifStall, (i % 5) != 4);
    end

    // Back-to-back loader read and fetch: no cross-routing.
    applyStimulus(0, 0, 1, 0, 32'h8, 0);
    applyStimulus(1, 32'hC, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("b2b_ld_rvalid", ldRvalid, 1);
    checkOutput("b2b_ld_rdata", ldRdata, 32'hC0DE0002);
    checkOutput("b2b_if_rvalid0", ifRvalid, 0);
    checkOutput("b2b_if_rdata0", ifRdata, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("b2b_if_rvalid", ifRvalid, 1);
    checkOutput("b2b_if_rdata", ifRdata, 32'hC0DE0003);
    checkOutput("b2b_ld_rvalid0", ldRvalid, 0);
    checkOutput("b2b_ld_rdata0", ldRdata, 0);

    // Misaligned fetch and wrap-around of the word index.
    applyStimulus(1, 32'h82, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("misal_mem_addr", memAddr, 0);
    checkOutput("misal_err_before", addrErr, 0);
    applyStimulus(1, 32'h84, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("wrap_mem_addr", memAddr, 1);
    checkOutput("misal_err_pulse", addrErr, 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("misal_err_clear", addrErr, 0);

    // Randomized traffic with occasional asynchronous resets.
    for (int n = 0; n < 800; n++) begin
      applyStimulus($urandom_range(0, 99) < 65, randAddr(), $urandom_range(0, 99) < 60,
                    1'($urandom_range(0, 1)), randAddr(), 32'($urandom()));
      if ($urandom_range(0, 149) == 0) begin
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
      end
    end

    applyStimulus(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
